div_ctrl: RTL

Sequencing controller between the EX stage and the shared 32-bit divider IP, which has AXI-stream-style operand inputs and a 64-bit {quotient, remainder} output.
- Accepts one divide request at a time over a valid/ready handshake and latches the operands.
- Issues the operands to the signed or unsigned IP, waits for the IP result, selects quotient or remainder, and holds the response until the stage consumes it.
- Handles divide-by-zero and signed overflow locally, plus pipeline flush and a watchdog timeout.
- Drives `busy` to the hazard/stall logic.

---
 rtl/div_ctrl_if.sv | 24 ++
 rtl/div_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/div_ctrl_if.sv
// Stage-side request/response handshake between the EX stage and the divider controller.
interface div_ctrl_if #(
  parameter int W = 32
);
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         resp_valid;
  logic         resp_ready;
  logic [W-1:0] resp_data;
  logic         resp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer between the EX stage and the shared divider IP: operand issue, result selection,
// local divide-by-zero/overflow bypass, flush draining and watchdog timeout.
module div_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  div_ctrl_if.slave     st,
  input  logic          flush,
  output logic          busy,
  output logic          div_tvalid,
  input  logic          div_tready,
  output logic          div_signed,
  output logic [W-1:0]  div_dividend,
  output logic [W-1:0]  div_divisor,
  input  logic          div_dout_valid,
  input  logic [2*W-1:0] div_dout
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT);
  localparam logic [W-1:0]  MIN_INT   = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          accept;
  logic          b_zero;
  logic          ovf;
  logic          cnt_hit;

  // rst_n gates req_ready so the stage sees 0 while reset is held.
  assign st.req_ready  = rst_n && (state == IDLE) && !flush;
  assign st.resp_valid = (state == DONE);
  assign div_tvalid    = (state == ISSUE);

  assign accept  = st.req_valid && st.req_ready;
  assign b_zero  = (st.req_b == '0);
  assign ovf     = !st.req_op[1] && (st.req_a == MIN_INT) && (st.req_b == '1);
  assign cnt_hit = (cnt == CNT_LIMIT);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = (b_zero || ovf) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (div_tready) begin
          state_nx = flush ? DRAIN : WAIT;
        end else if (flush) begin
          state_nx = IDLE;
        end
      end
      WAIT: begin
        // A flush that coincides with the IP finishing leaves nothing outstanding to drain.
        if (flush) begin
          state_nx = (div_dout_valid || cnt_hit) ? IDLE : DRAIN;
        end else if (div_dout_valid || cnt_hit) begin
          state_nx = DONE;
        end
      end
      DRAIN: begin
        if (div_dout_valid || cnt_hit) begin
          state_nx = IDLE;
        end
      end
      DONE: begin
        if (flush || st.resp_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      cnt          <= '0;
      op_q         <= '0;
      div_signed   <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      st.resp_data <= '0;
      st.resp_err  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);

      if (accept) begin
        op_q         <= st.req_op;
        div_signed   <= !st.req_op[1];
        div_dividend <= st.req_a;
        div_divisor  <= st.req_b;
        st.resp_err  <= 1'b0;
        if (b_zero) begin
          st.resp_data <= st.req_op[0] ? st.req_a : '1;
        end else if (ovf) begin
          st.resp_data <= st.req_op[0] ? '0 : MIN_INT;
        end
      end

      if (state == ISSUE && div_tready) begin
        cnt <= '0;
      end else if (state == WAIT || state == DRAIN) begin
        cnt <= cnt + CW'(1);
      end

      if (state == WAIT && !flush) begin
        if (div_dout_valid) begin
          st.resp_data <= op_q[0] ? div_dout[W-1:0] : div_dout[2*W-1:W];
        end else if (cnt_hit) begin
          st.resp_data <= '0;
          st.resp_err  <= 1'b1;
        end
      end

      if (state == DONE && state_nx == IDLE) begin
        st.resp_err <= 1'b0;
      end
    end
  end

endmodule
